march_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the 16-word x 2-bit single-port SRAM. It runs March C- over every address and compares registered read data against the expected background. It reports pass/fail plus optional first-failure diagnostics. It sits between the test-mode top level and the SRAM's `address`/`we_n`/`cs_n`/`data_in`/`data_out` pins; the SRAM's own `rst_n` is driven by the top level, not by this block.

---
 rtl/march_bist_ctrl_if.sv | 32 +++
 rtl/march_bist_ctrl.sv | 173 +++++++++++++++++
 tb/tb_march_bist_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/march_bist_ctrl_if.sv
// Bus bundle between the March C- BIST sequencer, the test-mode top level and the SRAM pins.
// slave = sequencer side, master = top level / SRAM side.
interface march_bist_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 2,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
    logic [CNT_W-1:0]  fail_count;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we_n;
    logic              mem_cs_n;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  start, mem_rdata,
        output busy, done, fail, fail_addr, fail_elem, fail_count,
               mem_addr, mem_we_n, mem_cs_n, mem_wdata
    );

    modport master (
        output start, mem_rdata,
        input  busy, done, fail, fail_addr, fail_elem, fail_count,
               mem_addr, mem_we_n, mem_cs_n, mem_wdata
    );
endinterface

// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer for a single-port SRAM, one memory op per cycle, registered read compare.
// Define MBIST_DIAG_EN to implement first-failure address/element and the mismatch counter.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | issuing the 10*depth march ops
// DRAIN | comparing the final read, port idle
// DONE  | status valid, waiting for start
module march_bist_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 2,
    parameter int CNT_W  = 8
) (
    input logic              clk,
    input logic              rst,
    march_bist_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] IDX_MAX = '1;
    localparam logic [2:0]        E_LAST  = 3'd5;

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              ph_q, ph_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_exp_q, rd_exp_d;
    logic              fail_q, fail_d;

    logic              op_rd, rbg, wbg, desc, addr_last_op, mismatch;
    logic [ADDR_W-1:0] op_addr;

    // E1..E5 start each address with a read; E0 is write-only, E5 read-only.
    assign op_rd        = (elem_q != 3'd0) && !ph_q;
    assign rbg          = (elem_q == 3'd2) || (elem_q == 3'd4);
    assign wbg          = (elem_q == 3'd1) || (elem_q == 3'd3);
    assign desc         = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign addr_last_op = (elem_q == 3'd0) || (elem_q == E_LAST) || ph_q;
    assign op_addr      = desc ? ~idx_q : idx_q;
    assign mismatch     = rd_pend_q && (bus.mem_rdata != {DATA_W{rd_exp_q}});

`ifdef MBIST_DIAG_EN
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]        rd_elem_q, rd_elem_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            elem_q    <= '0;
            idx_q     <= '0;
            ph_q      <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_exp_q  <= 1'b0;
            fail_q    <= 1'b0;
`ifdef MBIST_DIAG_EN
            rd_addr_q   <= '0;
            rd_elem_q   <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            elem_q    <= elem_d;
            idx_q     <= idx_d;
            ph_q      <= ph_d;
            rd_pend_q <= rd_pend_d;
            rd_exp_q  <= rd_exp_d;
            fail_q    <= fail_d;
`ifdef MBIST_DIAG_EN
            rd_addr_q   <= rd_addr_d;
            rd_elem_q   <= rd_elem_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_cnt_q  <= fail_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        idx_d     = idx_q;
        ph_d      = ph_q;
        rd_pend_d = 1'b0;
        rd_exp_d  = rd_exp_q;
        fail_d    = fail_q;
`ifdef MBIST_DIAG_EN
        rd_addr_d   = rd_addr_q;
        rd_elem_d   = rd_elem_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_cnt_d  = fail_cnt_q;
`endif
        bus.mem_cs_n  = 1'b1;
        bus.mem_we_n  = 1'b1;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        if (mismatch) begin
            fail_d = 1'b1;
`ifdef MBIST_DIAG_EN
            if (!fail_q) begin
                fail_addr_d = rd_addr_q;
                fail_elem_d = rd_elem_q;
            end
            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
`endif
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    elem_d  = '0;
                    idx_d   = '0;
                    ph_d    = 1'b0;
                    fail_d  = 1'b0;
`ifdef MBIST_DIAG_EN
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    fail_cnt_d  = '0;
`endif
                end
            end
            RUN: begin
                bus.mem_cs_n  = 1'b0;
                bus.mem_we_n  = op_rd;
                bus.mem_addr  = op_addr;
                bus.mem_wdata = {DATA_W{op_rd ? rbg : wbg}};
                if (op_rd) begin
                    rd_pend_d = 1'b1;
                    rd_exp_d  = rbg;
`ifdef MBIST_DIAG_EN
                    rd_addr_d = op_addr;
                    rd_elem_d = elem_q;
`endif
                end
                if (!addr_last_op) begin
                    ph_d = 1'b1;
                end else begin
                    ph_d  = 1'b0;
                    idx_d = idx_q + ADDR_W'(1);
                    if (idx_q == IDX_MAX) begin
                        elem_d = elem_q + 3'd1;
                        if (elem_q == E_LAST) state_d = DRAIN;
                    end
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done = (state_q == DONE);
    assign bus.fail = fail_q;

`ifdef MBIST_DIAG_EN
    assign bus.fail_addr  = fail_addr_q;
    assign bus.fail_elem  = fail_elem_q;
    assign bus.fail_count = fail_cnt_q;
`else
    assign bus.fail_addr  = '0;
    assign bus.fail_elem  = '0;
    assign bus.fail_count = '0;
`endif
endmodule

// File: tb/tb_march_bist_ctrl.sv
// Scoreboard bench for march_bist_ctrl: expected memory ops and end-of-run status are queued
// by the driver and popped by a negedge monitor; a behavioural 16x2 SRAM can inject stuck-at-1.
module tb_march_bist_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 2;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 16;
    localparam int NOPS   = 10 * DEPTH;

    typedef struct packed {
        int         cyc;
        logic       we_n;
        logic [3:0] addr;
        logic [1:0] wdata;
    } op_t;

    typedef struct packed {
        int         cyc;
        logic       fail;
        logic [3:0] fa;
        logic [2:0] fe;
        logic [7:0] fc;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    march_bist_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

    march_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    bit  fault_en = 1'b0;
    op_t op_q[$];
    st_t st_q[$];

    // March C- element table: read present/background, write present/background, descending
    bit has_rd[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit rd_bg[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit has_wr[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit wr_bg[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bit is_dsc[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] sram [DEPTH];
    logic [1:0] sram_rdata = 2'b00;
    always @(posedge clk) begin
        if (!bus.mem_cs_n) begin
            if (!bus.mem_we_n) sram[bus.mem_addr] <= bus.mem_wdata;
            else if (fault_en && bus.mem_addr == 4'd5) sram_rdata <= sram[bus.mem_addr] | 2'b10;
            else sram_rdata <= sram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = sram_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push_ops(input int s, input int n_ops);
        int n = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [3:0] a;
                a = is_dsc[e] ? 4'(DEPTH - 1 - i) : 4'(i);
                if (has_rd[e]) begin
                    if (n < n_ops) op_q.push_back('{s + n, 1'b1, a, {2{rd_bg[e]}}});
                    n++;
                end
                if (has_wr[e]) begin
                    if (n < n_ops) op_q.push_back('{s + n, 1'b0, a, {2{wr_bg[e]}}});
                    n++;
                end
            end
        end
    endtask

    // Raise start for one edge; queue expectations before the edge so the monitor never races them.
    task automatic launch(input int n_ops, input bit exp_st, input bit f, input logic [3:0] fa,
                          input logic [2:0] fe, input logic [7:0] fc, output int s);
        @(negedge clk);
        bus.start = 1'b1;
        s = cyc + 1;
        push_ops(s, n_ops);
        if (exp_st) st_q.push_back('{s + NOPS + 1, f, fa, fe, fc});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk_drained(input string name);
        chk({name, "_status_seen"}, 64'(st_q.size()), 64'd0);
        chk({name, "_ops_seen"}, 64'(op_q.size()), 64'd0);
    endtask

    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (!bus.mem_cs_n) begin
            if (op_q.size() == 0) begin
                chk("unexpected_op", 64'({bus.mem_we_n, bus.mem_addr, bus.mem_wdata}), 64'h7F);
            end else begin
                op_t exp_op, act_op;
                exp_op = op_q.pop_front();
                act_op = '{cyc, bus.mem_we_n, bus.mem_addr, bus.mem_wdata};
                chk("mem_op", 64'(act_op), 64'(exp_op));
            end
        end else begin
            chk("mem_idle", 64'({bus.mem_we_n, bus.mem_addr, bus.mem_wdata}), 64'h40);
        end
        if (bus.done && !done_prev) begin
            if (st_q.size() == 0) begin
                chk("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
                st_t exp_st, act_st;
                exp_st = st_q.pop_front();
                act_st = '{cyc, bus.fail, bus.fail_addr, bus.fail_elem, bus.fail_count};
                chk("done_status", 64'(act_st), 64'(exp_st));
                chk("busy_at_done", 64'(bus.busy), 64'd0);
            end
        end
        done_prev <= bus.done;
    end

`ifdef MBIST_DIAG_EN
    localparam logic [3:0] F_ADDR = 4'd5;
    localparam logic [2:0] F_ELEM = 3'd1;
    localparam logic [7:0] F_CNT  = 8'd3;
`else
    localparam logic [3:0] F_ADDR = 4'd0;
    localparam logic [2:0] F_ELEM = 3'd0;
    localparam logic [7:0] F_CNT  = 8'd0;
`endif

    initial begin
        int s;
        int s5;
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_values",
            64'({bus.busy, bus.done, bus.fail, bus.fail_addr, bus.fail_elem, bus.fail_count,
                 bus.mem_cs_n, bus.mem_we_n, bus.mem_addr, bus.mem_wdata}),
            64'({1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 8'd0, 1'b1, 1'b1, 4'd0, 2'd0}));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fault-free run
        launch(NOPS, 1'b1, 1'b0, 4'd0, 3'd0, 8'd0, s);
        wait_until(s + NOPS);
        chk("busy_last_cycle", 64'({bus.busy, bus.done}), 64'b10);
        wait_until(s + NOPS + 2);
        chk("done_holds", 64'({bus.busy, bus.done}), 64'b01);
        chk_drained("clean");

        // Stuck-at-1 on bit 1 of address 5
        fault_en = 1'b1;
        launch(NOPS, 1'b1, 1'b1, F_ADDR, F_ELEM, F_CNT, s);
        wait_until(s + NOPS + 2);
        chk_drained("stuck");

        // Reset in the middle of a faulty run
        launch(51, 1'b0, 1'b0, 4'd0, 3'd0, 8'd0, s);
        wait_until(s + 50);
        chk("fail_before_rst", 64'(bus.fail), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("after_rst",
            64'({bus.mem_cs_n, bus.busy, bus.done, bus.fail, bus.fail_count}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
        chk_drained("rst_abort");
        fault_en = 1'b0;
        launch(NOPS, 1'b1, 1'b0, 4'd0, 3'd0, 8'd0, s);
        wait_until(s + NOPS + 2);
        chk_drained("post_rst");

        // Start retriggered mid-run, then held high across done
        fault_en = 1'b1;
        launch(NOPS, 1'b1, 1'b1, F_ADDR, F_ELEM, F_CNT, s);
        wait_until(s + 20);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_until(s + NOPS);
        bus.start = 1'b1;
        fault_en = 1'b0;
        s5 = s + NOPS + 2;
        push_ops(s5, NOPS);
        st_q.push_back('{s5 + NOPS + 1, 1'b0, 4'd0, 3'd0, 8'd0});
        wait_until(s + NOPS + 1);
        chk("held_done_on", 64'({bus.busy, bus.done}), 64'b01);
        wait_until(s + NOPS + 2);
        chk("held_done_off", 64'({bus.busy, bus.done}), 64'b10);
        wait_until(s5 + 10);
        bus.start = 1'b0;
        wait_until(s5 + NOPS + 2);
        chk_drained("held");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
